// File: rtl/mul_div_unit.sv
// mul_div_unit: multiply/divide unit with HI/LO registers for the E stage.
// A started mult/div computes its exact result at the start edge into
// pending registers, then holds Busy for a fixed number of cycles before
// committing the pending pair into HI/LO. mthi/mtlo write directly.
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] E_MDU_A,
    input  logic [WIDTH-1:0] E_MDU_B,
    input  logic [3:0]       E_MDU_Op,
    input  logic             E_MDU_Start,
    output logic             E_MDU_Busy,
    output logic [WIDTH-1:0] E_MDU_HI,
    output logic [WIDTH-1:0] E_MDU_LO,
    output logic [WIDTH-1:0] E_MDU_Result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic               pend_we_q, pend_we_d;

    // Arithmetic datapath results for the current operands
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               b_nz;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   b_mag_safe;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   sq_mag;
    logic [WIDTH-1:0]   sr_mag;
    logic [WIDTH-1:0]   sq;
    logic [WIDTH-1:0]   sr;

    // Exact products and quotients; divisors are forced non-zero so the
    // divider never sees 0 (a zero divisor suppresses the commit instead).
    always_comb begin
        // Sign-extending both factors to 2*WIDTH makes the truncated
        // unsigned product equal to the two's-complement signed product.
        prod_s = {{WIDTH{E_MDU_A[WIDTH-1]}}, E_MDU_A} * {{WIDTH{E_MDU_B[WIDTH-1]}}, E_MDU_B};
        prod_u = {{WIDTH{1'b0}}, E_MDU_A} * {{WIDTH{1'b0}}, E_MDU_B};

        b_nz   = |E_MDU_B;
        b_safe = b_nz ? E_MDU_B : WIDTH'(1);
        uq     = E_MDU_A / b_safe;
        ur     = E_MDU_A % b_safe;

        // Signed division on magnitudes. The most-negative dividend has a
        // magnitude that still fits unsigned, so MIN / -1 naturally yields
        // quotient MIN and remainder 0.
        a_neg      = E_MDU_A[WIDTH-1];
        b_neg      = E_MDU_B[WIDTH-1];
        a_mag      = a_neg ? -E_MDU_A : E_MDU_A;
        b_mag      = b_neg ? -E_MDU_B : E_MDU_B;
        b_mag_safe = b_nz ? b_mag : WIDTH'(1);
        sq_mag     = a_mag / b_mag_safe;
        sr_mag     = a_mag % b_mag_safe;
        sq         = (a_neg ^ b_neg) ? -sq_mag : sq_mag;
        sr         = a_neg ? -sr_mag : sr_mag;
    end

    // Next-state logic: accept work in IDLE, count down and commit in RUN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        case (state_q)
            ST_IDLE: begin
                if (E_MDU_Start) begin
                    case (E_MDU_Op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
                            pend_lo_d = prod_s[WIDTH-1:0];
                            pend_we_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            busy_d    = 1'b1;
                            state_d   = ST_RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
                            pend_lo_d = prod_u[WIDTH-1:0];
                            pend_we_d = 1'b1;
                            cnt_d     = MULT_CNT;
                            busy_d    = 1'b1;
                            state_d   = ST_RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = sr;
                            pend_lo_d = sq;
                            pend_we_d = b_nz;
                            cnt_d     = DIV_CNT;
                            busy_d    = 1'b1;
                            state_d   = ST_RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = ur;
                            pend_lo_d = uq;
                            pend_we_d = b_nz;
                            cnt_d     = DIV_CNT;
                            busy_d    = 1'b1;
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: hi_d = E_MDU_A;
                        OP_MTLO: lo_d = E_MDU_A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Any Start seen here is ignored; the hazard unit never
                // issues one, but it must not disturb the running op.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign E_MDU_Busy = busy_q;
    assign E_MDU_HI   = hi_q;
    assign E_MDU_LO   = lo_q;

    // mfhi/mflo read the registers as they are right now
    always_comb begin
        E_MDU_Result = '0;
        if (E_MDU_Op == OP_MFHI) begin
            E_MDU_Result = hi_q;
        end else if (E_MDU_Op == OP_MFLO) begin
            E_MDU_Result = lo_q;
        end
    end

endmodule
